// File: rtl/x_conditioner_pkg.sv
// x_conditioner_pkg
// Shared definitions for the button conditioner: the debounce FSM state
// encoding and the default synchronizer depth and debounce length.
package x_conditioner_pkg;

  typedef enum logic [1:0] {
    LO      = 2'd0,
    WAIT_HI = 2'd1,
    HI      = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/x_conditioner_sync.sv
// sync_chain
// Plain flop chain that brings an asynchronous level into the clk domain.
// Ports:
//   clk  - clock, all flops update on the rising edge
//   rst  - synchronous active-low reset, clears every stage
//   d    - asynchronous input level
//   q    - synchronized level (last stage)
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage_r;

  // Shift the raw level through DEPTH flops; stage 0 is the metastable one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_r <= '0;
    end else begin
      stage_r <= {stage_r[DEPTH-2:0], d};
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/x_conditioner.sv
// x_conditioner
// Conditions a bouncy button into a clean level for a downstream counter:
// synchronizer, four-state debounce FSM with a qualification counter,
// edge strobes, and an optional toggle (push-on/push-off) mode.
// Ports:
//   clk        - clock
//   rst        - synchronous active-low reset
//   btn_raw    - asynchronous bouncy button level
//   mode       - 0 = level mode, 1 = toggle mode (quasi-static)
//   x          - conditioned level (debounced level or toggle state)
//   rise_pulse - one-cycle strobe, first cycle the debounced level is 1
//   fall_pulse - one-cycle strobe, first cycle the debounced level is 0
//   busy       - high while a candidate transition is being qualified
module x_conditioner
  import x_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic mode,
  output logic x,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  // Value at which the last qualifying sample completes the transition.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            btn_s;
  deb_state_t      state_r;
  deb_state_t      state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            rise_s;
  logic            fall_s;
  logic            rise_r;
  logic            fall_r;
  logic            busy_r;
  logic            tgl_r;
  logic            deb_s;

  sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  // State, counter and output strobe registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= LO;
      cnt_r   <= '0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      busy_r  <= (state_next_s == WAIT_HI) || (state_next_s == WAIT_LO);
    end
  end

  // Next-state, counter and strobe decode. The counter is loaded with 1 on
  // entry to a WAIT state and the exit happens at CNT_LAST, so it can never
  // exceed DEBOUNCE_CYCLES-1 and never wraps.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    rise_s       = 1'b0;
    fall_s       = 1'b0;
    case (state_r)
      LO: begin
        if (btn_s) begin
          state_next_s = WAIT_HI;
          cnt_next_s   = {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_next_s = LO;
        end
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_next_s = LO;
          cnt_next_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = HI;
          cnt_next_s   = '0;
          rise_s       = 1'b1;
        end else begin
          cnt_next_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      HI: begin
        if (!btn_s) begin
          state_next_s = WAIT_LO;
          cnt_next_s   = {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_next_s = HI;
        end
      end
      WAIT_LO: begin
        if (btn_s) begin
          state_next_s = HI;
          cnt_next_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = LO;
          cnt_next_s   = '0;
          fall_s       = 1'b1;
        end else begin
          cnt_next_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next_s = LO;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Toggle state flips at the end of every cycle in which rise_pulse is high,
  // independent of mode so switching modes never loses presses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tgl_r <= 1'b0;
    end else begin
      tgl_r <= tgl_r ^ rise_r;
    end
  end

  assign deb_s      = (state_r == HI) || (state_r == WAIT_LO);
  // Mode selects between two registered sources so a mode change shows up
  // on x immediately without touching any state.
  assign x          = mode ? tgl_r : deb_s;
  assign rise_pulse = rise_r;
  assign fall_pulse = fall_r;
  assign busy       = busy_r;

endmodule
